// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates sqNs, records writebacks, retires up to WIDTH per cycle with trap/flush recovery.
// Commit and trap outputs are registered (1 cycle after done); enqueue stalls via OUT_enqReady when fewer than WIDTH entries are free.
module reorder_buffer #(
  parameter int LENGTH   = 64,
  parameter int WIDTH    = 4,
  parameter int WIDTH_WB = 4,
  parameter int TAG_W    = 7,
  parameter int SQN_W    = $clog2(LENGTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          IN_enqValid,
  input  logic [WIDTH*TAG_W-1:0]    IN_enqTag,
  input  logic [WIDTH*5-1:0]        IN_enqRd,
  input  logic [WIDTH-1:0]          IN_enqDone,
  output logic                      OUT_enqReady,
  output logic [SQN_W-1:0]          OUT_tailSqN,
  input  logic [WIDTH_WB-1:0]       IN_wbValid,
  input  logic [WIDTH_WB*SQN_W-1:0] IN_wbSqN,
  input  logic [WIDTH_WB*3-1:0]     IN_wbFlags,
  input  logic                      IN_flushValid,
  input  logic [SQN_W-1:0]          IN_flushSqN,
  input  logic                      IN_singleStep,
  output logic [WIDTH-1:0]          OUT_comValid,
  output logic [WIDTH*SQN_W-1:0]    OUT_comSqN,
  output logic [WIDTH*TAG_W-1:0]    OUT_comTag,
  output logic [WIDTH*5-1:0]        OUT_comRd,
  output logic                      OUT_trapValid,
  output logic [SQN_W-1:0]          OUT_trapSqN,
  output logic [2:0]                OUT_trapFlags,
  output logic [SQN_W-1:0]          OUT_headSqN,
  output logic [SQN_W-1:0]          OUT_count
);
  localparam int IDX_W = SQN_W - 1;

  logic [SQN_W-1:0]       r_head, r_tail;
  logic [LENGTH-1:0]      r_valid, r_done;
  logic [2:0]             r_flags [LENGTH];
  logic [TAG_W-1:0]       r_tag   [LENGTH];
  logic [4:0]             r_rd    [LENGTH];

  logic [WIDTH-1:0]       r_comValid;
  logic [WIDTH*SQN_W-1:0] r_comSqN;
  logic [WIDTH*TAG_W-1:0] r_comTag;
  logic [WIDTH*5-1:0]     r_comRd;
  logic                   r_trapValid;
  logic [SQN_W-1:0]       r_trapSqN;
  logic [2:0]             r_trapFlags;

  logic [SQN_W-1:0]       w_count, w_nret, w_enqCnt, w_trapSqN;
  logic [WIDTH-1:0]       w_retire;
  logic                   w_trap, w_run, w_keep, w_enq;
  logic [2:0]             w_trapFlags;
  logic [SQN_W-1:0]       w_lsqn [WIDTH];
  logic [IDX_W-1:0]       w_tidx [WIDTH];
  logic [SQN_W-1:0]       w_wsqn [WIDTH_WB];
  logic [SQN_W-1:0]       w_esqn [LENGTH];

  // True when a is strictly younger than b in wrapped sqN space.
  function automatic logic younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic signed [SQN_W-1:0] d;
    d = a - b;
    return d > 0;
  endfunction

  assign w_count      = r_tail - r_head;
  assign OUT_enqReady = (w_count <= SQN_W'(LENGTH - WIDTH));
  assign OUT_tailSqN  = r_tail;
  assign OUT_headSqN  = r_head;
  assign OUT_count    = w_count;
  assign OUT_comValid = r_comValid;
  assign OUT_comSqN   = r_comSqN;
  assign OUT_comTag   = r_comTag;
  assign OUT_comRd    = r_comRd;
  assign OUT_trapValid = r_trapValid;
  assign OUT_trapSqN  = r_trapSqN;
  assign OUT_trapFlags = r_trapFlags;

  always_comb begin
    w_retire    = '0;
    w_nret      = '0;
    w_trap      = 1'b0;
    w_trapSqN   = r_head;
    w_trapFlags = 3'd0;
    w_run       = 1'b1;
    w_keep      = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_lsqn[i] = r_head + SQN_W'(i);
      // Never retire or trap on an entry that a same-cycle flush is about to squash.
      w_keep = !(IN_flushValid && younger(w_lsqn[i], IN_flushSqN));
      if (w_run) begin
        if (r_valid[w_lsqn[i][IDX_W-1:0]] && r_done[w_lsqn[i][IDX_W-1:0]] &&
            r_flags[w_lsqn[i][IDX_W-1:0]] == 3'd0 && w_keep && (i == 0 || !IN_singleStep)) begin
          w_retire[i] = 1'b1;
          w_nret      = w_nret + SQN_W'(1);
        end else begin
          w_run = 1'b0;
          if (r_valid[w_lsqn[i][IDX_W-1:0]] && r_done[w_lsqn[i][IDX_W-1:0]] && w_keep &&
              r_flags[w_lsqn[i][IDX_W-1:0]] != 3'd0) begin
            w_trap      = 1'b1;
            w_trapSqN   = w_lsqn[i];
            w_trapFlags = r_flags[w_lsqn[i][IDX_W-1:0]];
          end
        end
      end
    end
  end

  always_comb begin
    w_enqCnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_tidx[i] = r_tail[IDX_W-1:0] + IDX_W'(i);
      w_enqCnt  = w_enqCnt + SQN_W'(IN_enqValid[i]);
    end
    for (int j = 0; j < WIDTH_WB; j++) w_wsqn[j] = IN_wbSqN[j*SQN_W +: SQN_W];
    // Rebuild each slot's full sqN relative to head so the wrap bit is right.
    for (int e = 0; e < LENGTH; e++) w_esqn[e] = r_head + {1'b0, IDX_W'(e) - r_head[IDX_W-1:0]};
  end

  assign w_enq = OUT_enqReady && !IN_flushValid && !w_trap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_valid     <= '0;
      r_comValid  <= '0;
      r_comSqN    <= '0;
      r_comTag    <= '0;
      r_comRd     <= '0;
      r_trapValid <= 1'b0;
      r_trapSqN   <= '0;
      r_trapFlags <= 3'd0;
    end else begin
      r_comValid  <= w_retire;
      r_trapValid <= w_trap;
      for (int i = 0; i < WIDTH; i++) begin
        if (w_retire[i]) begin
          r_comSqN[i*SQN_W +: SQN_W] <= w_lsqn[i];
          r_comTag[i*TAG_W +: TAG_W] <= r_tag[w_lsqn[i][IDX_W-1:0]];
          r_comRd[i*5 +: 5]          <= r_rd[w_lsqn[i][IDX_W-1:0]];
        end
      end
      if (w_trap) begin
        r_trapSqN   <= w_trapSqN;
        r_trapFlags <= w_trapFlags;
        r_valid     <= '0;
        r_head      <= w_trapSqN;
        r_tail      <= w_trapSqN;
      end else begin
        if (w_enq) begin
          for (int i = 0; i < WIDTH; i++)
            if (IN_enqValid[i]) r_valid[w_tidx[i]] <= 1'b1;
        end
        for (int i = 0; i < WIDTH; i++)
          if (w_retire[i]) r_valid[w_lsqn[i][IDX_W-1:0]] <= 1'b0;
        r_head <= r_head + w_nret;
        if (IN_flushValid) begin
          for (int e = 0; e < LENGTH; e++)
            if (younger(w_esqn[e], IN_flushSqN)) r_valid[e] <= 1'b0;
          r_tail <= IN_flushSqN + SQN_W'(1);
        end else if (w_enq) begin
          r_tail <= r_tail + w_enqCnt;
        end
      end
    end
  end

  // Payload needs no reset; r_valid alone decides whether a slot is live.
  always_ff @(posedge clk) begin
    if (!w_trap) begin
      for (int j = 0; j < WIDTH_WB; j++) begin
        if (IN_wbValid[j] && !(IN_flushValid && younger(w_wsqn[j], IN_flushSqN))) begin
          r_done[w_wsqn[j][IDX_W-1:0]]  <= 1'b1;
          r_flags[w_wsqn[j][IDX_W-1:0]] <= IN_wbFlags[j*3 +: 3];
        end
      end
    end
    if (w_enq) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (IN_enqValid[i]) begin
          r_done[w_tidx[i]]  <= IN_enqDone[i];
          r_flags[w_tidx[i]] <= 3'd0;
          r_tag[w_tidx[i]]   <= IN_enqTag[i*TAG_W +: TAG_W];
          r_rd[w_tidx[i]]    <= IN_enqRd[i*5 +: 5];
        end
      end
    end
  end
endmodule
